// File: rtl/disp_scan_ctrl_pkg.sv
// disp_scan_ctrl_pkg: shared display constants, register bundle and anode encoding
package disp_scan_ctrl_pkg;

    localparam int N_DIGITS      = 4;
    localparam int SCAN_DIV_DEF  = 17;
    localparam int BLINK_DIV_DEF = 25;

    typedef struct packed {
        logic [N_DIGITS*4-1:0] hexs;
        logic [N_DIGITS-1:0]   points;
        logic [N_DIGITS-1:0]   les;
        logic [N_DIGITS-1:0]   flash_en;
    } disp_regs_t;

    function automatic logic [N_DIGITS-1:0] an_sel(input logic [1:0] idx);
        return ~(N_DIGITS'(1) << idx);
    endfunction

endpackage

// File: rtl/disp_scan_ctrl_if.sv
// disp_scan_ctrl_if: host write port plus scan outputs toward the segment decoder
interface disp_scan_ctrl_if;
    import disp_scan_ctrl_pkg::*;

    logic                  wr_en;
    logic [N_DIGITS*4-1:0] wr_hexs;
    logic [N_DIGITS-1:0]   wr_points;
    logic [N_DIGITS-1:0]   wr_les;
    logic [N_DIGITS-1:0]   wr_flash_en;
    logic                  wr_ack;
    logic [N_DIGITS-1:0]   AN;
    logic [3:0]            digit_hex;
    logic                  digit_point;
    logic                  digit_le;
    logic                  digit_flash;
    logic                  frame_tick;

    modport master (
        output wr_en, wr_hexs, wr_points, wr_les, wr_flash_en,
        input  wr_ack, AN, digit_hex, digit_point, digit_le, digit_flash, frame_tick
    );

    modport slave (
        input  wr_en, wr_hexs, wr_points, wr_les, wr_flash_en,
        output wr_ack, AN, digit_hex, digit_point, digit_le, digit_flash, frame_tick
    );

endinterface

// File: rtl/disp_scan_ctrl_prescaler.sv
// disp_prescaler: free-running W-bit counter; wrap is high on the all-ones cycle
module disp_prescaler #(
    parameter int W = 17
) (
    input  logic clk,
    input  logic rst,
    output logic wrap
);

    logic [W-1:0] cnt;

    // count up every cycle, rolling over naturally
    always_ff @(posedge clk) begin
        if (rst) cnt <= '0;
        else     cnt <= cnt + 1'b1;
    end

    assign wrap = &cnt;

endmodule

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: four-digit scan controller with frame-synchronous write commit
module disp_scan_ctrl
    import disp_scan_ctrl_pkg::*;
#(
    parameter int SCAN_DIV  = SCAN_DIV_DEF,
    parameter int BLINK_DIV = BLINK_DIV_DEF
) (
    input logic             clk,
    input logic             rst,
    disp_scan_ctrl_if.slave bus
);

    logic       scan_wrap, blink_wrap;
    logic [1:0] idx, idx_nx;
    logic       blink_phase, blink_phase_nx;
    logic       pending, boundary, commit;
    disp_regs_t act, act_nx, pend;

    disp_prescaler #(.W(SCAN_DIV)) u_scan (
        .clk  (clk),
        .rst  (rst),
        .wrap (scan_wrap)
    );

    disp_prescaler #(.W(BLINK_DIV)) u_blink (
        .clk  (clk),
        .rst  (rst),
        .wrap (blink_wrap)
    );

    // next-state values so digit data and AN move on the same edge, including the commit edge
    always_comb begin
        boundary       = scan_wrap && idx == 2'd3;
        commit         = boundary && pending;
        idx_nx         = scan_wrap ? idx + 2'd1 : idx;
        blink_phase_nx = blink_phase ^ blink_wrap;
        act_nx         = commit ? pend : act;
    end

    // state, pending buffer and registered decoder/anode outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            idx             <= 2'd0;
            blink_phase     <= 1'b0;
            act             <= '0;
            pend            <= '0;
            pending         <= 1'b0;
            bus.wr_ack      <= 1'b0;
            bus.frame_tick  <= 1'b0;
            bus.AN          <= an_sel(2'd0);
            bus.digit_hex   <= 4'd0;
            bus.digit_point <= 1'b0;
            bus.digit_le    <= 1'b0;
            bus.digit_flash <= 1'b1;
        end else begin
            idx             <= idx_nx;
            blink_phase     <= blink_phase_nx;
            act             <= act_nx;
            if (bus.wr_en) begin
                pend    <= '{bus.wr_hexs, bus.wr_points, bus.wr_les, bus.wr_flash_en};
                pending <= 1'b1;
            end else if (boundary) begin
                pending <= 1'b0;
            end
            bus.wr_ack      <= commit;
            bus.frame_tick  <= boundary;
            bus.AN          <= an_sel(idx_nx);
            bus.digit_hex   <= act_nx.hexs[{idx_nx, 2'b00} +: 4];
            bus.digit_point <= act_nx.points[idx_nx];
            bus.digit_le    <= act_nx.les[idx_nx];
            bus.digit_flash <= act_nx.flash_en[idx_nx] ? blink_phase_nx : 1'b1;
        end
    end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb_disp_scan_ctrl: directed checks of scan, frame commit, blink and reset behaviour
module tb_disp_scan_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   k = 0;
    int   acks = 0;
    int   ack_k = -1;

    disp_scan_ctrl_if bus();

    disp_scan_ctrl #(.SCAN_DIV(2), .BLINK_DIV(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (k=%0d)", tag, got, exp, k);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        k++;
        if (bus.wr_ack) begin
            acks++;
            ack_k = k;
        end
    endtask

    task automatic run_to(input int t);
        while (k < t) tick();
    endtask

    task automatic wr(input logic [15:0] h, input logic [3:0] p, input logic [3:0] l, input logic [3:0] f);
        bus.wr_hexs     = h;
        bus.wr_points   = p;
        bus.wr_les      = l;
        bus.wr_flash_en = f;
        bus.wr_en       = 1'b1;
        tick();
        bus.wr_en       = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_an"},    16'(bus.AN),          16'hE);
        check({tag, "_hex"},   16'(bus.digit_hex),   16'h0);
        check({tag, "_pt"},    16'(bus.digit_point), 16'h0);
        check({tag, "_le"},    16'(bus.digit_le),    16'h0);
        check({tag, "_fl"},    16'(bus.digit_flash), 16'h1);
        check({tag, "_ack"},   16'(bus.wr_ack),      16'h0);
        check({tag, "_frame"}, 16'(bus.frame_tick),  16'h0);
    endtask

    initial begin
        bus.wr_en       = 1'b0;
        bus.wr_hexs     = '0;
        bus.wr_points   = '0;
        bus.wr_les      = '0;
        bus.wr_flash_en = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        k = 0;
        check_reset_outputs("reset");

        // idle scan: each digit held 4 cycles, frame every 16
        for (int i = 1; i <= 20; i++) begin
            tick();
            check("idle_an",    16'(bus.AN),          16'(4'hF ^ (4'b0001 << ((k / 4) % 4))));
            check("idle_frame", 16'(bus.frame_tick),  16'(k % 16 == 0));
            check("idle_flash", 16'(bus.digit_flash), 16'h1);
        end

        // mid-frame write, committed at the k=32 boundary
        acks = 0;
        wr(16'h3A7F, 4'b0101, 4'b1111, 4'b0000);
        run_to(31);
        check("w1_noack",  16'(acks),             16'd0);
        check("w1_hold",   16'(bus.digit_hex),    16'h0);
        run_to(32);
        check("w1_ack",    16'(bus.wr_ack),       16'h1);
        check("w1_frame",  16'(bus.frame_tick),   16'h1);
        check("w1_an0",    16'(bus.AN),           16'hE);
        check("w1_hex0",   16'(bus.digit_hex),    16'hF);
        check("w1_pt0",    16'(bus.digit_point),  16'h1);
        check("w1_le0",    16'(bus.digit_le),     16'h1);
        run_to(36);
        check("w1_an1",    16'(bus.AN),           16'hD);
        check("w1_hex1",   16'(bus.digit_hex),    16'h7);
        check("w1_pt1",    16'(bus.digit_point),  16'h0);
        run_to(40);
        check("w1_hex2",   16'(bus.digit_hex),    16'hA);
        run_to(44);
        check("w1_hex3",   16'(bus.digit_hex),    16'h3);
        check("w1_acks",   16'(acks),             16'd1);

        // two writes in one frame: last wins, single ack
        acks = 0;
        wr(16'h1111, 4'b0000, 4'b0000, 4'b0000);
        tick();
        wr(16'h2222, 4'b0000, 4'b0000, 4'b0000);
        run_to(48);
        check("w2_ackk", 16'(ack_k), 16'd48);
        for (int d = 0; d < 4; d++) begin
            run_to(48 + 4 * d);
            check("w2_hex", 16'(bus.digit_hex), 16'h2);
        end
        run_to(63);
        check("w2_acks", 16'(acks), 16'd1);

        // write exactly on the boundary cycle with nothing pending
        acks = 0;
        wr(16'hC0DE, 4'b0000, 4'b0000, 4'b0010);
        check("wb_frame", 16'(bus.frame_tick), 16'h1);
        check("wb_noack", 16'(bus.wr_ack),     16'h0);
        check("wb_hold",  16'(bus.digit_hex),  16'h2);
        run_to(80);
        check("wb_acks",  16'(acks),           16'd1);
        check("wb_ackk",  16'(ack_k),          16'd80);
        check("wb_hex0",  16'(bus.digit_hex),  16'hE);
        check("wb_fl0",   16'(bus.digit_flash), 16'h1);
        run_to(84);
        check("wb_hex1",  16'(bus.digit_hex),  16'hD);
        check("fl_d1_p1", 16'(bus.digit_flash), 16'h1);
        run_to(96);
        check("fl_d0",    16'(bus.digit_flash), 16'h1);
        run_to(100);
        check("fl_an",    16'(bus.AN),          16'hD);
        check("fl_d1_p0", 16'(bus.digit_flash), 16'h0);
        run_to(104);
        check("fl_d2",    16'(bus.digit_flash), 16'h1);
        run_to(116);
        check("fl_d1_p1b", 16'(bus.digit_flash), 16'h1);
        run_to(132);
        check("fl_d1_p0b", 16'(bus.digit_flash), 16'h0);

        // pending write discarded by reset before the boundary
        acks = 0;
        wr(16'hFFFF, 4'hF, 4'hF, 4'hF);
        run_to(136);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        k = 0;
        check_reset_outputs("rst_mid");
        run_to(16);
        check("rst_hex_f1",  16'(bus.digit_hex),  16'h0);
        check("rst_frame",   16'(bus.frame_tick), 16'h1);
        run_to(36);
        check("rst_hex_f2",  16'(bus.digit_hex),  16'h0);
        check("rst_le",      16'(bus.digit_le),   16'h0);
        check("rst_noack",   16'(acks),           16'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/disp_scan_ctrl.md
Name: disp_scan_ctrl

Overview:
- Four-digit seven-segment scan controller for the board display.
- Time-multiplexes one shared hex-to-segment decoder across four anodes.
- Feeds the decoder its Hex, point, LE and flash inputs for the currently selected digit, and drives the active-low anode strobes.
- Host writes display contents through a one-cycle write strobe; writes are committed only at frame boundaries to avoid tearing. Commit is acknowledged.

Parameters:
- SCAN_DIV, 17: width of the scan prescaler; each digit is held for 2^SCAN_DIV clk cycles.
- BLINK_DIV, 25: width of the blink prescaler; blink phase toggles every 2^BLINK_DIV clk cycles.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous, active-high reset.
- wr_en, input, 1: one-cycle write strobe.
- wr_hexs, input, 16: four nibbles; [3:0] is digit 0.
- wr_points, input, 4: decimal point per digit.
- wr_les, input, 4: LE per digit.
- wr_flash_en, input, 4: per-digit blink enable.
- wr_ack, output, 1: one-cycle pulse when pending data is committed.
- AN, output, 4: anode select, active-low one-hot.
- digit_hex, output, 4: drives decoder Hex.
- digit_point, output, 1: drives decoder point.
- digit_le, output, 1: drives decoder LE.
- digit_flash, output, 1: drives decoder flash.
- frame_tick, output, 1: one-cycle pulse at each frame boundary.

Behaviour:
- One clock domain (clk). rst is synchronous, active-high. All outputs are registered.
- Reset values:
  - scan_cnt = 0, idx = 0, blink_cnt = 0, blink_phase = 0.
  - Active registers (hexs, points, les, flash_en) = 0. Pending registers = 0, pending flag = 0.
  - AN = 4'b1110, digit_hex = 0, digit_point = 0, digit_le = 0, digit_flash = 1.
  - wr_ack = 0, frame_tick = 0.
- Scan:
  - scan_cnt (SCAN_DIV bits) increments every cycle and wraps to 0.
  - On the cycle scan_cnt is all-ones, idx advances 0->1->2->3->0 (2-bit wrap).
  - AN = ~(4'b0001 << idx).
- Frame boundary: scan_cnt all-ones AND idx == 3. On that cycle:
  - frame_tick asserts for one cycle, coincident with the wrap.
  - If pending = 1: active registers take the pending values, pending clears, and wr_ack pulses for one cycle.
- Digit outputs: registered from the active registers indexed by the next idx, so they change in the same clock edge as AN. No cycle exists in which AN and the digit data mismatch.
  - digit_hex = hexs[idx*4+:4]
  - digit_point = points[idx]
  - digit_le = les[idx]
  - digit_flash = flash_en[idx] ? blink_phase : 1
- Blink: blink_cnt (BLINK_DIV bits) is free-running. blink_phase toggles when blink_cnt wraps. It is independent of the scan.
- Write path:
  - wr_en = 1 loads all four wr_* buses into the pending registers and sets pending.
  - Multiple writes before a boundary: last write wins; a single wr_ack is produced.
  - wr_en on the boundary cycle itself: commit uses the pending values held before that edge. The new write then becomes pending, with pending = 1 after the edge. If pending was 0 on that cycle, nothing commits and the write waits for the next frame.
  - wr_en held high is treated as a write every cycle.
- Reset mid-frame: returns to the reset state in one edge and discards pending data; no wr_ack is issued.
- Worst-case write-to-display latency: 4*2^SCAN_DIV + 1 cycles.

Decomposition:
- Shared display package holds:
  - N_DIGITS = 4 and the AN one-hot/active-low encoding.
  - The default SCAN_DIV and BLINK_DIV values.
  - The struct grouping hexs/points/les/flash_en, used for both the pending and active registers.
- One natural sub-module: disp_prescaler, a parameterised free-running counter with a wrap pulse, instantiated twice (scan and blink).
- The segment decoder stays outside this block; the top level wires digit_* into it.

Test Plan (SCAN_DIV=2, BLINK_DIV=4):
- Reset, then idle 20 cycles -> AN cycles 1110, 1101, 1011, 0111, each held 4 cycles; frame_tick pulses every 16 cycles; digit_flash = 1 throughout.
- Write wr_hexs=16'h3A7F, wr_points=4'b0101, wr_les=4'b1111 mid-frame -> outputs unchanged until the boundary, then wr_ack coincides with frame_tick. After that edge:
  - AN = 1110 with digit_hex = F, digit_point = 1.
  - AN = 1101 with digit_hex = 7, digit_point = 0.
- Two writes in one frame (h1111, then h2222) -> a single wr_ack; digit_hex shows 2 on all digits after commit.
- Write asserted exactly on the boundary cycle, with pending = 0 -> no wr_ack that frame; commit and wr_ack occur 16 cycles later.
- wr_flash_en=4'b0010 -> digit_flash follows blink_phase (toggles every 16 cycles) only while AN = 1101; it is 1 for the other digits.
- Pending write, then rst asserted before the boundary -> all outputs return to reset values; no wr_ack thereafter; digit_hex = 0.
